// File: rtl/mips_pipeline_pkg.sv
// Shared MIPS pipeline definitions: fetch defaults, NOP encoding and the
// IF/ID payload record that is also consumed by the decode stage.
package mips_pipeline_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;

  localparam logic [XLEN-1:0] NOP_INSTR          = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC   = 32'h0000_0000;
  localparam int unsigned     DEFAULT_IMEM_WORDS = 66;

  // IF/ID pipeline payload
  typedef struct packed {
    logic [XLEN-1:0] instruction;
    logic [XLEN-1:0] pcplus4;
    logic            valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instruction: NOP_INSTR, pcplus4: '0, valid: 1'b0};

  // Word index of a byte address lies beyond the populated instruction memory
  function automatic logic word_out_of_range(input logic [XLEN-1:0] addr,
                                             input int unsigned     words);
    return addr[XLEN-1:2] >= (XLEN-2)'(words);
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction memory port and
// IF/ID outputs. master = pipeline control + memory side, slave = fetch stage.
interface fetch_stage_if;
  import mips_pipeline_pkg::*;

  logic            stall;
  logic            flush;
  logic            redirect;
  logic [XLEN-1:0] redirect_target;
  logic [XLEN-1:0] imem_address;
  logic [XLEN-1:0] imem_instruction;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] if_id_instruction;
  logic [XLEN-1:0] if_id_pcplus4;
  logic            if_id_valid;
  logic            addr_err;

  modport master (
    output stall, flush, redirect, redirect_target, imem_instruction,
    input  imem_address, pc, if_id_instruction, if_id_pcplus4, if_id_valid, addr_err
  );

  modport slave (
    input  stall, flush, redirect, redirect_target, imem_instruction,
    output imem_address, pc, if_id_instruction, if_id_pcplus4, if_id_valid, addr_err
  );
endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register with clear (bubble), hold and load controls.
// Ports: clk, rst (async active-high), clear, hold, d (payload in), q (payload out).
// clear has priority over hold.
module if_id_register
  import mips_pipeline_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clear,
  input  logic   hold,
  input  if_id_t d,
  output if_id_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= IF_ID_BUBBLE;
    end else if (clear) begin
      q <= IF_ID_BUBBLE;
    end else if (!hold) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection, fetch range
// and alignment checks, and the IF/ID register.
// Ports: clk, rst (async active-high), bus (fetch_stage_if.slave):
//   in : stall, flush, redirect, redirect_target, imem_instruction
//   out: imem_address (= pc), pc, if_id_instruction, if_id_pcplus4,
//        if_id_valid, addr_err (sticky until reset)
module fetch_stage
  import mips_pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned IMEM_WORDS = DEFAULT_IMEM_WORDS
) (
  input  logic          clk,
  input  logic          rst,
  fetch_stage_if.slave  bus
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_plus4;
  logic            fetch_oor;
  logic            capture;
  logic            err_set;
  logic            addr_err_q;
  if_id_t          if_id_d;
  if_id_t          if_id_q;

  assign pc_plus4  = pc_q + XLEN'(WORD_BYTES);
  assign fetch_oor = word_out_of_range(pc_q, IMEM_WORDS);
  assign capture   = !bus.redirect && !bus.flush && !bus.stall;

  // Next-PC priority: redirect (word-aligned target), stall, sequential
  always_comb begin
    pc_next = pc_plus4;
    if (bus.redirect) begin
      pc_next = {bus.redirect_target[XLEN-1:2], 2'b00};
    end else if (bus.stall) begin
      pc_next = pc_q;
    end
  end

  // Out-of-range fetches enter IF/ID as a bubble that still carries PC+4
  always_comb begin
    if_id_d.instruction = fetch_oor ? NOP_INSTR : bus.imem_instruction;
    if_id_d.pcplus4     = pc_plus4;
    if_id_d.valid       = !fetch_oor;
  end

  assign err_set = (capture && fetch_oor) ||
                   (bus.redirect && (bus.redirect_target[1:0] != 2'b00));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      addr_err_q <= 1'b0;
    end else begin
      pc_q       <= pc_next;
      addr_err_q <= addr_err_q | err_set;
    end
  end

  if_id_register u_if_id (
    .clk   (clk),
    .rst   (rst),
    .clear (bus.redirect | bus.flush),
    .hold  (bus.stall),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign bus.imem_address      = pc_q;
  assign bus.pc                = pc_q;
  assign bus.if_id_instruction = if_id_q.instruction;
  assign bus.if_id_pcplus4     = if_id_q.pcplus4;
  assign bus.if_id_valid       = if_id_q.valid;
  assign bus.addr_err          = addr_err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, async reset
// sequence, and randomized run against a behavioural model.
module tb_fetch_stage;
  import mips_pipeline_pkg::*;

  localparam int unsigned NWORDS = 66;

  logic clk = 1'b0;
  logic rst = 1'b1;
  fetch_stage_if bus ();

  fetch_stage #(.RESET_PC(32'h0), .IMEM_WORDS(NWORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: words past NWORDS hold junk the DUT must not pass on
  logic [31:0] mem [128];
  always_comb begin
    if (bus.imem_address[31:9] == 23'd0)
      bus.imem_instruction = mem[bus.imem_address[8:2]];
    else
      bus.imem_instruction = 32'hBAD0_BAD0;
  end

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model state
  logic [31:0] m_pc, m_ins, m_pp4;
  logic        m_v, m_err;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a[31:2] < 30'(NWORDS)) ? mem[a[8:2]] : 32'h0;
  endfunction

  task automatic model_reset();
    m_pc = 32'h0; m_ins = 32'h0; m_pp4 = 32'h0; m_v = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic f, input logic r, input logic [31:0] tgt);
    logic [31:0] npc;
    logic        oor;
    oor = (m_pc >> 2) >= NWORDS;
    if (r)      npc = tgt & ~32'd3;
    else if (s) npc = m_pc;
    else        npc = m_pc + 32'd4;
    if (r || f) begin
      m_ins = 32'h0; m_pp4 = 32'h0; m_v = 1'b0;
    end else if (!s) begin
      m_pp4 = m_pc + 32'd4;
      m_ins = oor ? 32'h0 : mem_word(m_pc);
      m_v   = !oor;
      if (oor) m_err = 1'b1;
    end
    if (r && tgt[1:0] != 2'b00) m_err = 1'b1;
    m_pc = npc;
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                           input logic [31:0] pp4, input logic v, input logic err);
    check({tag, ".pc"},   bus.pc, pc);
    check({tag, ".addr"}, bus.imem_address, pc);
    check({tag, ".ins"},  bus.if_id_instruction, ins);
    check({tag, ".pp4"},  bus.if_id_pcplus4, pp4);
    check({tag, ".v"},    32'(bus.if_id_valid), 32'(v));
    check({tag, ".err"},  32'(bus.addr_err), 32'(err));
  endtask

  task automatic drive(input logic s, input logic f, input logic r, input logic [31:0] tgt);
    bus.stall = s; bus.flush = f; bus.redirect = r; bus.redirect_target = tgt;
  endtask

  // Called at posedge+1; reset pulse lands between edges
  task automatic pulse_reset();
    drive(0, 0, 0, 32'h0);
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic        rst_first;
    logic        s, f, r;
    logic [31:0] tgt;
    logic [31:0] pc, ins, pp4;
    logic        v, err;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rf, input logic s, input logic f, input logic r,
                              input logic [31:0] tgt, input logic [31:0] pc, input logic [31:0] ins,
                              input logic [31:0] pp4, input logic v, input logic err);
    vec_t x;
    x.rst_first = rf; x.s = s; x.f = f; x.r = r; x.tgt = tgt;
    x.pc = pc; x.ins = ins; x.pp4 = pp4; x.v = v; x.err = err;
    return x;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 128; i++)
      mem[i] = (i < int'(NWORDS)) ? (32'hA000_0000 | 32'(i)) : (32'hDEAD_0000 | 32'(i));
    mem[0] = 32'h2010_0001;
    mem[1] = 32'h2011_0001;
    mem[2] = 32'h0211_8024;

    // rf  s f r  tgt            pc             ins            pp4           v  err
    vq.push_back(mk(0, 0,0,0, 32'h0,         32'h4,         32'h2010_0001, 32'h4,        1, 0));
    vq.push_back(mk(0, 0,0,0, 32'h0,         32'h8,         32'h2011_0001, 32'h8,        1, 0));
    vq.push_back(mk(0, 1,0,0, 32'h0,         32'h8,         32'h2011_0001, 32'h8,        1, 0));
    vq.push_back(mk(0, 1,0,0, 32'h0,         32'h8,         32'h2011_0001, 32'h8,        1, 0));
    vq.push_back(mk(0, 0,0,0, 32'h0,         32'hC,         32'h0211_8024, 32'hC,        1, 0));
    vq.push_back(mk(0, 0,0,1, 32'h10,        32'h10,        32'h0,         32'h0,        0, 0));
    vq.push_back(mk(0, 0,0,0, 32'h0,         32'h14,        32'hA000_0004, 32'h14,       1, 0));
    vq.push_back(mk(0, 1,0,1, 32'h10,        32'h10,        32'h0,         32'h0,        0, 0));
    vq.push_back(mk(0, 0,0,0, 32'h0,         32'h14,        32'hA000_0004, 32'h14,       1, 0));
    vq.push_back(mk(0, 0,0,1, 32'h12,        32'h10,        32'h0,         32'h0,        0, 1));
    vq.push_back(mk(0, 0,0,0, 32'h0,         32'h14,        32'hA000_0004, 32'h14,       1, 1));
    vq.push_back(mk(1, 0,0,1, 32'h100,       32'h100,       32'h0,         32'h0,        0, 0));
    vq.push_back(mk(0, 0,0,0, 32'h0,         32'h104,       32'hA000_0040, 32'h104,      1, 0));
    vq.push_back(mk(0, 0,0,0, 32'h0,         32'h108,       32'hA000_0041, 32'h108,      1, 0));
    vq.push_back(mk(0, 1,0,0, 32'h0,         32'h108,       32'hA000_0041, 32'h108,      1, 0));
    vq.push_back(mk(0, 0,1,0, 32'h0,         32'h10C,       32'h0,         32'h0,        0, 0));
    vq.push_back(mk(0, 0,0,1, 32'h108,       32'h108,       32'h0,         32'h0,        0, 0));
    vq.push_back(mk(0, 0,0,0, 32'h0,         32'h10C,       32'h0,         32'h10C,      0, 1));
    vq.push_back(mk(0, 0,0,1, 32'h0,         32'h0,         32'h0,         32'h0,        0, 1));
    vq.push_back(mk(0, 0,0,0, 32'h0,         32'h4,         32'h2010_0001, 32'h4,        1, 1));
    vq.push_back(mk(0, 1,1,0, 32'h0,         32'h4,         32'h0,         32'h0,        0, 1));
    vq.push_back(mk(0, 0,0,0, 32'h0,         32'h8,         32'h2011_0001, 32'h8,        1, 1));
    vq.push_back(mk(1, 0,0,1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,         32'h0,        0, 0));
    vq.push_back(mk(0, 0,0,0, 32'h0,         32'h0,         32'h0,         32'h0,        0, 1));
    vq.push_back(mk(0, 0,0,0, 32'h0,         32'h4,         32'h2010_0001, 32'h4,        1, 1));

    // Reset state, held across an edge
    drive(0, 0, 0, 32'h0);
    @(posedge clk); #1;
    check_all("reset", 32'h0, 32'h0, 32'h0, 0, 0);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // First vector expects PC=4 after one edge from reset, so re-align
    pulse_reset();
    // pulse_reset consumed one edge: redo a clean reset so the table starts at PC=0
    rst = 1'b1; #2 rst = 1'b0;
    check_all("post_reset", 32'h0, 32'h0, 32'h0, 0, 0);

    foreach (vq[i]) begin
      if (vq[i].rst_first) begin
        rst = 1'b1; #2;
        check_all($sformatf("v%0d.rst", i), 32'h0, 32'h0, 32'h0, 0, 0);
        rst = 1'b0;
      end
      drive(vq[i].s, vq[i].f, vq[i].r, vq[i].tgt);
      @(posedge clk); #1;
      check_all($sformatf("v%0d", i), vq[i].pc, vq[i].ins, vq[i].pp4, vq[i].v, vq[i].err);
    end

    // Async reset mid-run at PC=40, with a stale error flag set beforehand
    drive(0, 0, 1, 32'h1);
    @(posedge clk); #1;
    drive(0, 0, 1, 32'h28);
    @(posedge clk); #1;
    drive(0, 0, 0, 32'h0);
    check("async.pre_pc", bus.pc, 32'h28);
    check("async.pre_err", 32'(bus.addr_err), 32'd1);
    #2 rst = 1'b1;
    #1;
    check_all("async.now", 32'h0, 32'h0, 32'h0, 0, 0);
    @(posedge clk); #1;
    check_all("async.held", 32'h0, 32'h0, 32'h0, 0, 0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check_all("async.first", 32'h4, 32'h2010_0001, 32'h4, 1, 0);

    // Randomized run against the model
    rst = 1'b1; #2 rst = 1'b0;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      logic        s, f, r;
      logic [31:0] tgt;
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 9) == 0);
      tgt = 32'($urandom_range(0, 300));
      if ($urandom_range(0, 3) != 0) tgt = tgt & ~32'd3;
      if (!r && $urandom_range(0, 1) == 0) tgt = $urandom;
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1; #2 rst = 1'b0;
        model_reset();
      end
      drive(s, f, r, tgt);
      model_step(s, f, r, tgt);
      @(posedge clk); #1;
      check_all($sformatf("rnd%0d", n), m_pc, m_ins, m_pp4, m_v, m_err);
    end

    drive(0, 0, 0, 32'h0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline, directly upstream of the instruction memory.
- Holds the program counter and drives the memory address.
- Captures the returned instruction and PC+4 into the IF/ID pipeline register.
- Handles stall, flush and branch/jump redirect from later stages; flags out-of-range and misaligned fetches.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IMEM_WORDS, 66, number of valid instruction words; word index PC[31:2] >= IMEM_WORDS is out of range.

Ports:
- Clk  in  1  system clock, rising-edge.
- Rst  in  1  asynchronous, active-high reset.
- Stall  in  1  hold PC and IF/ID (load-use hazard).
- Flush  in  1  replace IF/ID contents with a bubble.
- Redirect  in  1  branch taken / jump / jr.
- RedirectTarget  in  32  new PC when Redirect=1.
- IMemAddress  out  32  address to instruction memory; combinationally equal to PC.
- IMemInstruction  in  32  combinational read data from instruction memory.
- PC  out  32  current program counter.
- IF_ID_Instruction  out  32  registered instruction.
- IF_ID_PCPlus4  out  32  registered PC+4 of that instruction.
- IF_ID_Valid  out  1  1 = IF/ID holds a real instruction.
- AddrErr  out  1  sticky fetch-address error flag.

Behaviour:
- Reset (async, immediate on Rst=1, held while Rst=1): PC=RESET_PC, IF_ID_Instruction=32'h0 (NOP), IF_ID_PCPlus4=0, IF_ID_Valid=0, AddrErr=0. Reset asserted mid-operation discards everything, with no partial state kept.
- IMemAddress = PC at all times, including during reset.
- Next PC, evaluated at each rising edge, priority high to low:
  - Redirect: {RedirectTarget[31:2],2'b00}
  - Stall: PC
  - else: PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- Redirect overrides Stall for the PC.
- IF/ID update at each rising edge, priority high to low:
  - Redirect or Flush: Instruction=0, PCPlus4=0, Valid=0.
  - Stall: hold all three.
  - else: Instruction=IMemInstruction, PCPlus4=PC+4, Valid=1.
  - Exception to the capture case: if PC[31:2] >= IMEM_WORDS, capture Instruction=0 and Valid=0; PCPlus4 is still PC+4.
- AddrErr is set, and stays set until reset, when either:
  - an out-of-range capture occurs (capture case only, not while stalled or flushed), or
  - Redirect=1 with RedirectTarget[1:0] != 0.
- Latency:
  - The instruction at address A appears on IF_ID_Instruction one rising edge after PC=A, provided no Stall/Flush/Redirect on that edge.
  - Redirect costs exactly one bubble: the target instruction reaches IF/ID on the second edge after Redirect.
- First edge after Rst deasserts captures memory[RESET_PC>>2].
- Simultaneous Stall+Flush without Redirect: PC holds, IF/ID becomes a bubble.
- No combinational path from Stall/Flush/Redirect to any output. All outputs except IMemAddress are registered.

Decomposition:
- Shared package mips_pipeline_pkg:
  - NOP_INSTR = 32'h0000_0000
  - WORD_BYTES = 4
  - default RESET_PC and IMEM_WORDS values
  - a struct/typedef for the IF/ID payload {Instruction, PCPlus4, Valid}, reused by the decode stage.
- One natural sub-module: if_id_register. It holds the IF/ID payload with hold/clear/load controls and async reset. fetch_stage keeps the PC register, the next-PC mux and the range/alignment checks.

Test Plan:
- Reset then free-run, with memory[0]=32'h20100001, memory[1]=32'h20110001, memory[2]=32'h02118024 -> after edges 1, 2, 3: IF_ID_Instruction = those words in order; IF_ID_PCPlus4 = 4, 8, 12; Valid=1; PC=12.
- Stall held 2 cycles at PC=8 -> PC stays 8; IF/ID holds 32'h20110001 / PCPlus4=8; on release the next edge captures 32'h02118024.
- Redirect=1, RedirectTarget=32'h0000_0010 at PC=8 -> next edge: PC=16, Valid=0, Instruction=0; following edge: IF/ID captures memory[4], PCPlus4=20.
- Redirect+Stall same edge -> PC takes target 32'h10, IF/ID bubble; RedirectTarget=32'h0000_0012 -> PC=32'h10, AddrErr=1.
- Run to PC=264 (word 66) -> captured Instruction=0, Valid=0, AddrErr=1; AddrErr stays 1 after redirect to 0, clears only on Rst.
- Assert Rst mid-run at PC=40, asynchronously between edges -> PC=RESET_PC and Valid=0 immediately without a clock edge; first edge after release captures memory[0].
